midi_transmitter: RTL

MIDI_TRANSMITTER -- requirements
Module: midi_transmitter

---
 rtl/midi_transmitter_pkg.sv | 37 +++
 rtl/midi_transmitter_uart_byte_tx.sv | 97 +++++++++
 rtl/midi_transmitter.sv | 103 ++++++++++
 3 files changed

// File: rtl/midi_transmitter_pkg.sv
// Shared MIDI definitions for the transmit and receive paths: message layout,
// message-type codes, serializer states and the data-byte-count helper.
package MIDI;

    typedef struct packed {
        logic [3:0] message_type;
        logic [3:0] channel;
        logic [7:0] data_byte1;
        logic [7:0] data_byte2;
    } message_t;

    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] POLY_PRESSURE    = 4'hA;
    localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
    localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
    localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
    localparam logic [3:0] PITCH_BEND       = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Zero marks a type that is not a channel-voice message and must be dropped.
    function automatic logic [1:0] data_byte_count(input logic [3:0] message_type);
        case (message_type)
            NOTE_OFF, NOTE_ON, POLY_PRESSURE,
            CONTROL_CHANGE, PITCH_BEND:        return 2'd2;
            PROGRAM_CHANGE, CHANNEL_PRESSURE:  return 2'd1;
            default:                           return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/midi_transmitter_uart_byte_tx.sv
// 8N1 byte serializer. done pulses on the final clock of the stop bit; a start
// seen in that same cycle chains the next byte with no idle gap.
module uart_byte_tx #(
    parameter int CLOCKS_PER_BIT = 1600
) (
    input  logic       clock_50_000_000,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx,
    output logic       busy
);
    import MIDI::*;

    localparam int COUNT_WIDTH = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_TICK = COUNT_WIDTH'(CLOCKS_PER_BIT - 1);

    tx_state_t              state_reg;
    logic [COUNT_WIDTH-1:0] tick_reg;
    logic [2:0]             bit_index_reg;
    logic [7:0]             shift_reg;
    logic                   tx_reg;
    logic                   busy_reg;
    logic                   last_tick;

    assign last_tick = (tick_reg == LAST_TICK);
    assign done      = (state_reg == STOP) && last_tick;
    assign tx        = tx_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state_reg     <= IDLE;
            tick_reg      <= '0;
            bit_index_reg <= '0;
            shift_reg     <= '0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tick_reg <= '0;
                    if (start) begin
                        shift_reg <= data;
                        state_reg <= START;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                START: begin
                    if (last_tick) begin
                        tick_reg      <= '0;
                        bit_index_reg <= '0;
                        tx_reg        <= shift_reg[0];
                        state_reg     <= DATA;
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        tick_reg <= '0;
                        if (bit_index_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            // shift_reg[1] is the next bit before the shift lands
                            shift_reg     <= shift_reg >> 1;
                            tx_reg        <= shift_reg[1];
                            bit_index_reg <= bit_index_reg + 1'b1;
                        end
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        tick_reg <= '0;
                        if (start) begin
                            shift_reg <= data;
                            tx_reg    <= 1'b0;
                            state_reg <= START;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        tick_reg <= tick_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/midi_transmitter.sv
// MIDI channel-message transmitter: sequences status and data bytes into
// uart_byte_tx. Optional running status is enabled by MIDI_RUNNING_STATUS_EN.
module midi_transmitter #(
    parameter int CLOCKS_PER_BIT = 1600
) (
    input  logic          clock_50_000_000,
    input  logic          reset,
    input  MIDI::message_t message,
    input  logic          message_valid,
    output logic          message_ready,
    output logic          tx,
    output logic          busy
);
    import MIDI::*;

    localparam logic [7:0] DATA_MASK = 8'h7F;

    logic       ready_reg;
    logic [1:0] pending_count_reg;
    logic [7:0] pending0_reg;
    logic [7:0] pending1_reg;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_reg;
`endif

    logic [7:0] status_byte;
    logic [7:0] data1_masked;
    logic [7:0] data2_masked;
    logic [7:0] first_byte;
    logic [7:0] byte_in;
    logic [1:0] byte_count;
    logic       accept;
    logic       drop;
    logic       skip_status;
    logic       start;
    logic       done;

    always_comb begin
        status_byte  = {message.message_type, message.channel};
        data1_masked = message.data_byte1 & DATA_MASK;
        data2_masked = message.data_byte2 & DATA_MASK;
        byte_count   = data_byte_count(message.message_type);
        drop         = (byte_count == 2'd0);
        accept       = message_valid && ready_reg;
`ifdef MIDI_RUNNING_STATUS_EN
        skip_status  = (status_byte == last_status_reg);
`else
        skip_status  = 1'b0;
`endif
        first_byte   = skip_status ? data1_masked : status_byte;
        // accept and done never coincide: ready is low while a frame runs
        start        = (accept && !drop) || (done && (pending_count_reg != 2'd0));
        byte_in      = accept ? first_byte : pending0_reg;
    end

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            ready_reg         <= 1'b1;
            pending_count_reg <= '0;
            pending0_reg      <= '0;
            pending1_reg      <= '0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_reg   <= '0;
`endif
        end else if (accept && !drop) begin
            ready_reg <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_reg <= status_byte;
`endif
            if (skip_status) begin
                pending0_reg      <= data2_masked;
                pending1_reg      <= '0;
                pending_count_reg <= byte_count - 2'd1;
            end else begin
                pending0_reg      <= data1_masked;
                pending1_reg      <= data2_masked;
                pending_count_reg <= byte_count;
            end
        end else if (done) begin
            if (pending_count_reg != 2'd0) begin
                pending0_reg      <= pending1_reg;
                pending_count_reg <= pending_count_reg - 2'd1;
            end else begin
                ready_reg <= 1'b1;
            end
        end
    end

    uart_byte_tx #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_uart_byte_tx (
        .clock_50_000_000 (clock_50_000_000),
        .reset            (reset),
        .start            (start),
        .data             (byte_in),
        .done             (done),
        .tx               (tx),
        .busy             (busy)
    );

    assign message_ready = ready_reg;

endmodule
